serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
Serial bit-stream transmitter, the driving end of the single-bit x_in interface used by the Problem 5.37 sequence-detector circuits. It takes a parallel WIDTH-bit pattern plus a repeat count, then shifts the pattern out MSB-first, one bit per clock, on x_out. It replaces hand-coded fork/join stimulus: benches instantiate it and wire x_out to the detectors' x_in.

Parameters:
WIDTH, 8, pattern length in bits (>=2)
CNT_W, 4, width of the repeat-count input
GAP, 0, idle cycles (x_out=0, bit_valid=0) inserted between repeats (0..15)

Ports:
clock  input  1  rising-edge system clock
reset_b  input  1  asynchronous reset, active-low
start  input  1  request transmission; sampled at rising edge
pattern  input  WIDTH  bits to send, MSB first; captured on accepted start
repeat_n  input  CNT_W  number of transmissions; 0 treated as 1; captured on accepted start
x_out  output  1  serial data; feeds detector x_in
bit_valid  output  1  high when x_out carries a pattern bit
busy  output  1  high in SHIFT and GAP
done  output  1  one-cycle pulse after the last bit of the last repeat

Behaviour:
- reset_b low, asynchronous: state=IDLE; x_out=0, bit_valid=0, busy=0, done=0. All internal registers clear. Applies immediately mid-transmission; no partial bits follow.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: outputs 0. At an edge with start=1: shreg<=pattern, bitcnt<=WIDTH-1, rep_left<=max(repeat_n,1), go to SHIFT.
- Latency: first bit appears the cycle after the accepting edge. x_out=shreg[WIDTH-1] and bit_valid=1 throughout SHIFT. x_out is 0 in every other state.
- SHIFT: each edge shifts shreg left by 1 (zero fill) and decrements bitcnt. At the edge where bitcnt==0:
  - rep_left>1 and GAP>0: go to GAP, gapcnt<=GAP-1, rep_left--.
  - rep_left>1 and GAP==0: reload shreg<=captured pattern, bitcnt<=WIDTH-1, stay in SHIFT, rep_left--. The stream is contiguous with no bubble.
  - rep_left==1: go to DONE.
- GAP: x_out=0, bit_valid=0, busy=1. At gapcnt==0, reload the pattern and go to SHIFT; otherwise gapcnt--.
- DONE: lasts exactly 1 cycle. done=1, busy=0, x_out=0. Next state is IDLE, unless start=1 at that edge: then accept as in IDLE (back-to-back transfers; done and the new capture happen in the same cycle).
- start is ignored in SHIFT and GAP. The pattern and repeat_n inputs may change freely after capture.
- Captured pattern is held in a separate register (pat_q) for reloads. shreg is never reloaded from the live inputs.
- Repeat accounting:
  - rep_left is CNT_W bits. The maximum of 2^CNT_W-1 repeats is exact.
  - Total SHIFT cycles = WIDTH*max(repeat_n,1).
  - Total GAP cycles = GAP*(max(repeat_n,1)-1).
- No combinational path from inputs to outputs. x_out is derived from registered state and shreg only.

Decomposition:
- Package serial_tx_pkg:
  - state enum {IDLE, SHIFT, GAP, DONE}, 2-bit encoding.
  - localparam width helper for bitcnt, $clog2(WIDTH).
  - localparam width helper for gapcnt, 4 bits.
- Sub-module piso_shift_reg:
  - Parallel-in serial-out register, WIDTH parameter.
  - Ports: clock, reset_b, load, shift, d, q_msb.
  - The top FSM drives load and shift.

Test Plan:
1. WIDTH=8, pattern=8'b1010_1010, repeat_n=1, start pulse at cycle 0 -> x_out=1,0,1,0,1,0,1,0 in cycles 1-8; bit_valid=1 in cycles 1-8; done=1 in cycle 9 only; busy=1 in cycles 1-8.
2. pattern=8'hF0, repeat_n=3, GAP=0 -> 24 contiguous valid bits (1111_0000 ×3) in cycles 1-24; done in cycle 25.
3. GAP=2, pattern=8'h81, repeat_n=2 -> bits in cycles 1-8; x_out=0 with bit_valid=0 in cycles 9-10; bits in cycles 11-18; done in cycle 19.
4. repeat_n=0, pattern=8'hC3 -> exactly one transmission (8 bits); done in cycle 9.
5. Second start with pattern=8'h00 at cycle 4 of an 8'hFF transfer -> ignored; x_out stays 1 through cycle 8. Then a start held high at the done cycle -> the next transfer's first bit appears in cycle 10.
6. reset_b low mid-transmission at cycle 4.5 -> x_out, bit_valid and busy drop to 0 immediately with no clock edge. After release, a fresh start yields a complete, correct 8-bit stream.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared state encoding and counter widths for serial_pattern_tx
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_e;

    localparam int GAP_W = 4;

    // Bit counter must hold WIDTH-1; never narrower than one bit.
    function automatic int bitcnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in serial-out register, MSB first, zero fill
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_msb
);

    logic [WIDTH-1:0] shreg;

    // load wins over shift so a reload on the last bit restarts cleanly
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= d;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign q_msb = shreg[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - repeats a captured pattern MSB-first on x_out with optional gaps
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             x_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int               BIT_W    = bitcnt_width(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    tx_state_e        state_q, state_d;
    logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             load, shift;
    logic [WIDTH-1:0] load_data;
    logic             q_msb;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            rep_q    <= '0;
            gap_q    <= '0;
            pat_q    <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            rep_q    <= rep_d;
            gap_q    <= gap_d;
            pat_q    <= pat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        pat_d     = pat_q;
        load      = 1'b0;
        shift     = 1'b0;
        load_data = pat_q;
        case (state_q)
            // DONE accepts a new start exactly like IDLE for back-to-back transfers
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_SHIFT;
                    pat_d     = pattern;
                    load      = 1'b1;
                    load_data = pattern;
                    bitcnt_d  = BIT_LAST;
                    rep_d     = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bitcnt_q != '0) begin
                    shift    = 1'b1;
                    bitcnt_d = bitcnt_q - 1'b1;
                end else if (rep_q > CNT_W'(1)) begin
                    rep_d = rep_q - 1'b1;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                        shift   = 1'b1;
                    end else begin
                        load     = 1'b1;
                        bitcnt_d = BIT_LAST;
                    end
                end else begin
                    state_d = ST_DONE;
                    shift   = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d  = ST_SHIFT;
                    load     = 1'b1;
                    bitcnt_d = BIT_LAST;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clock   (clock),
        .reset_b (reset_b),
        .load    (load),
        .shift   (shift),
        .d       (load_data),
        .q_msb   (q_msb)
    );

    // Outputs decode registered state only, so reset clears them without a clock.
    assign bit_valid = (state_q == ST_SHIFT);
    assign x_out     = bit_valid & q_msb;
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_GAP);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - directed self-checking bench for serial_pattern_tx
module tb_serial_pattern_tx;

    logic       clock = 1'b0;
    logic       reset_b;
    logic       start0, start2;
    logic [7:0] pattern;
    logic [3:0] repeat_n;
    logic       x0, bv0, bz0, dn0;
    logic       x2, bv2, bz2, dn2;
    logic [3:0] obs0, obs2;
    logic [3:0] tr [1:32];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    serial_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP(0)) dut0 (
        .clock     (clock),
        .reset_b   (reset_b),
        .start     (start0),
        .pattern   (pattern),
        .repeat_n  (repeat_n),
        .x_out     (x0),
        .bit_valid (bv0),
        .busy      (bz0),
        .done      (dn0)
    );

    serial_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP(2)) dut2 (
        .clock     (clock),
        .reset_b   (reset_b),
        .start     (start2),
        .pattern   (pattern),
        .repeat_n  (repeat_n),
        .x_out     (x2),
        .bit_valid (bv2),
        .busy      (bz2),
        .done      (dn2)
    );

    // {x_out, bit_valid, busy, done}
    assign obs0 = {x0, bv0, bz0, dn0};
    assign obs2 = {x2, bv2, bz2, dn2};

    // Leaves the bench at the sample point of cycle 1.
    task automatic start_xfer(input int which, input logic [7:0] pat, input logic [3:0] rn);
        @(negedge clock);
        pattern  = pat;
        repeat_n = rn;
        if (which == 0) start0 = 1'b1;
        else            start2 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic record(input int which, input int n);
        for (int i = 1; i <= n; i++) begin
            tr[i] = (which == 0) ? obs0 : obs2;
            if (i < n) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        start0 = 1'b0; start2 = 1'b0; pattern = '0; repeat_n = '0;
        repeat (2) @(negedge clock);
        checks++;
        if (obs0 !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gap0 got=%b exp=0000", obs0);
        end
        checks++;
        if (obs2 !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gap2 got=%b exp=0000", obs2);
        end
        reset_b = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single();
        logic [7:0] p;
        logic [3:0] e;
        p = 8'b1010_1010;
        start_xfer(0, p, 4'd1);
        record(0, 10);
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8)      e = {p[8-i], 3'b110};
            else if (i == 9) e = 4'b0001;
            else             e = 4'b0000;
            checks++;
            if (tr[i] !== e) begin
                failures++;
                $display("FAIL single cycle=%0d got=%b exp=%b", i, tr[i], e);
            end
        end
    endtask

    task automatic test_repeat_contig();
        logic [7:0] p;
        logic [3:0] e;
        p = 8'hF0;
        start_xfer(0, p, 4'd3);
        record(0, 26);
        for (int i = 1; i <= 26; i++) begin
            if (i <= 24)      e = {p[7-((i-1)%8)], 3'b110};
            else if (i == 25) e = 4'b0001;
            else              e = 4'b0000;
            checks++;
            if (tr[i] !== e) begin
                failures++;
                $display("FAIL repeat_contig cycle=%0d got=%b exp=%b", i, tr[i], e);
            end
        end
    endtask

    task automatic test_gap();
        logic [7:0] p;
        logic [3:0] e;
        p = 8'h81;
        start_xfer(2, p, 4'd2);
        record(2, 20);
        for (int i = 1; i <= 20; i++) begin
            if (i <= 8)               e = {p[8-i], 3'b110};
            else if (i <= 10)         e = 4'b0010;
            else if (i <= 18)         e = {p[18-i], 3'b110};
            else if (i == 19)         e = 4'b0001;
            else                      e = 4'b0000;
            checks++;
            if (tr[i] !== e) begin
                failures++;
                $display("FAIL gap cycle=%0d got=%b exp=%b", i, tr[i], e);
            end
        end
    endtask

    task automatic test_repeat_zero();
        logic [7:0] p;
        logic [3:0] e;
        p = 8'hC3;
        start_xfer(0, p, 4'd0);
        record(0, 12);
        for (int i = 1; i <= 12; i++) begin
            if (i <= 8)      e = {p[8-i], 3'b110};
            else if (i == 9) e = 4'b0001;
            else             e = 4'b0000;
            checks++;
            if (tr[i] !== e) begin
                failures++;
                $display("FAIL repeat_zero cycle=%0d got=%b exp=%b", i, tr[i], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p2;
        logic [3:0] e;
        p2 = 8'h5A;
        start_xfer(0, 8'hFF, 4'd1);
        for (int c = 1; c <= 19; c++) begin
            if (c <= 8)       e = 4'b1110;
            else if (c == 9)  e = 4'b0001;
            else if (c <= 17) e = {p2[17-c], 3'b110};
            else if (c == 18) e = 4'b0001;
            else              e = 4'b0000;
            checks++;
            if (obs0 !== e) begin
                failures++;
                $display("FAIL back_to_back cycle=%0d got=%b exp=%b", c, obs0, e);
            end
            if (c == 4)  begin start0 = 1'b1; pattern = 8'h00; repeat_n = 4'd5; end
            if (c == 5)  start0 = 1'b0;
            if (c == 9)  begin start0 = 1'b1; pattern = p2; repeat_n = 4'd1; end
            if (c == 10) begin start0 = 1'b0; pattern = 8'h00; repeat_n = 4'd7; end
            @(negedge clock);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] p;
        logic [3:0] e;
        start_xfer(0, 8'hFF, 4'd2);
        repeat (3) @(negedge clock);
        checks++;
        if (obs0 !== 4'b1110) begin
            failures++;
            $display("FAIL pre_reset got=%b exp=1110", obs0);
        end
        reset_b = 1'b0;
        #1;
        checks++;
        if (obs0 !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset got=%b exp=0000", obs0);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (obs0 !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=0000", obs0);
        end
        reset_b = 1'b1;
        p = 8'h3C;
        start_xfer(0, p, 4'd1);
        record(0, 10);
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8)      e = {p[8-i], 3'b110};
            else if (i == 9) e = 4'b0001;
            else             e = 4'b0000;
            checks++;
            if (tr[i] !== e) begin
                failures++;
                $display("FAIL after_reset cycle=%0d got=%b exp=%b", i, tr[i], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat_contig();
        test_gap();
        test_repeat_zero();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
